// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 16-bit WISC pipeline.
// Owns the fetch PC and runs a multi-cycle imem request/valid handshake.
// It loads the IF/ID register and handles stall (skid buffer), branch flush
// with draining of in-flight reads, and HLT detection.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pc              current fetch PC (to PC_control.PC_in)
//   next_pc         next PC from PC_control, used when an instruction is accepted
//   imem_req/addr   registered read request and address
//   imem_rdata      read data, qualified by imem_valid
//   imem_valid      one-cycle completion pulse for the outstanding request
//   stall           hazard hold; IF/ID and pc do not advance
//   flush           redirect from a later stage, fetch resumes at redirect_pc
//   if_id_instr     IF/ID instruction
//   if_id_pc_plus2  IF/ID PC+2
//   if_id_valid     IF/ID holds a real instruction
//   halted          a HLT has been accepted and fetch is stopped
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc,
  input  logic [15:0] next_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted
);

  localparam logic [3:0]  HLT_OPCODE = 4'hF;
  localparam logic [15:0] PC_STEP    = 16'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] skid_q, skid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pcp2_q, pcp2_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic        rsp_vld;
  logic        do_accept;
  logic [15:0] accept_instr;
  logic        read_pending;

  // Memory responses only count while our request is actually outstanding.
  assign rsp_vld = imem_valid & req_q;

  // A read is in flight and has not come back this cycle.
  assign read_pending = req_q & ~rsp_vld &
                        ((state_q == S_FETCH) | (state_q == S_DRAIN));

  // Next-state and next-register computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    skid_d       = skid_q;
    instr_d      = instr_q;
    pcp2_d       = pcp2_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    do_accept    = 1'b0;
    accept_instr = skid_q;

    if (flush) begin
      // Flush beats stall and acceptance everywhere.
      instr_d  = NOP_INSTR;
      pcp2_d   = 16'h0000;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      skid_d   = NOP_INSTR;
      pc_d     = redirect_pc;
      if (read_pending) begin
        // Keep the old request alive so its data can be swallowed in DRAIN.
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        addr_d  = redirect_pc;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (!req_q) begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end else if (rsp_vld) begin
            if (stall) begin
              skid_d  = imem_rdata;
              req_d   = 1'b0;
              state_d = S_HOLD;
            end else begin
              do_accept    = 1'b1;
              accept_instr = imem_rdata;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            do_accept    = 1'b1;
            accept_instr = skid_q;
          end
        end
        S_DRAIN: begin
          // Drop the stale data, then fetch from the (redirected) pc.
          if (rsp_vld) begin
            state_d = S_FETCH;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
        S_HALT: begin
          req_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase

      if (do_accept) begin
        instr_d = accept_instr;
        pcp2_d  = pc_q + PC_STEP;
        valid_d = 1'b1;
        if (accept_instr[15:12] == HLT_OPCODE) begin
          // HLT: pc stays on the HLT, no further requests.
          state_d  = S_HALT;
          req_d    = 1'b0;
          halted_d = 1'b1;
        end else begin
          state_d = S_FETCH;
          pc_d    = next_pc;
          req_d   = 1'b1;
          addr_d  = next_pc;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      skid_q   <= NOP_INSTR;
      instr_q  <= NOP_INSTR;
      pcp2_q   <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      skid_q   <= skid_d;
      instr_q  <= instr_d;
      pcp2_q   <= pcp2_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc             = pc_q;
  assign imem_req       = req_q;
  assign imem_addr      = addr_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus2 = pcp2_q;
  assign if_id_valid    = valid_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a latency-configurable
// instruction memory model, a scoreboard for accepted instructions, a vector
// table for the stall/skid sequence and hand-written corner-case sequences.
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .next_pc       (next_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .stall         (stall),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus2(if_id_pc_plus2),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcp2;
  } sb_t;

  typedef struct {
    logic        stall;
    logic [15:0] nxt;
    logic        req;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcp2;
    logic        valid;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[6];
  int          checks;
  int          errors;
  int          lat;
  int          cnt;
  logic        force_vld;
  logic [15:0] force_data;
  logic [15:0] halt_addr;
  logic [15:0] exp_pc;

  // Memory contents: HLT at halt_addr, otherwise opcode 1 tagged with the address.
  function automatic logic [15:0] mem(input logic [15:0] a);
    if (a == halt_addr) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  function automatic vec_t mk(input logic s, input logic [15:0] n, input logic r,
                              input logic [15:0] a, input logic [15:0] p,
                              input logic [15:0] i, input logic [15:0] p2,
                              input logic v);
    vec_t t;
    t.stall = s; t.nxt = n; t.req = r; t.addr = a;
    t.pc = p; t.instr = i; t.pcp2 = p2; t.valid = v;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, req_v, $time);
    end
  endtask

  // One clock: memory answers the current request, then the edge, then scoreboard.
  task automatic tick();
    sb_t e;
    if (force_vld) begin
      imem_valid = 1'b1;
      imem_rdata = force_data;
    end else if (imem_req === 1'b1 && cnt >= lat - 1) begin
      imem_valid = 1'b1;
      imem_rdata = mem(imem_addr);
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 16'hDEAD;
    end
    if (imem_req === 1'b1 && !imem_valid) cnt++;
    else cnt = 0;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("sb_instr", if_id_instr, e.instr);
      chk("sb_pcp2", if_id_pc_plus2, e.pcp2);
      chk("sb_valid", 16'(if_id_valid), 16'd1);
    end
  endtask

  // Zero-wait sequential acceptance of n instructions from exp_pc.
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      next_pc = exp_pc + 16'd2;
      sb_q.push_back({mem(exp_pc), 16'(exp_pc + 16'd2)});
      tick();
      exp_pc = exp_pc + 16'd2;
      chk("stream_pc", pc, exp_pc);
      chk("stream_addr", imem_addr, exp_pc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_req"}, 16'(imem_req), 16'd0);
    chk({tag, "_addr"}, imem_addr, RST_PC);
    chk({tag, "_instr"}, if_id_instr, NOP);
    chk({tag, "_pcp2"}, if_id_pc_plus2, 16'h0000);
    chk({tag, "_valid"}, 16'(if_id_valid), 16'd0);
    chk({tag, "_halted"}, 16'(halted), 16'd0);
  endtask

  initial begin
    checks = 0; errors = 0; lat = 1; cnt = 0;
    force_vld = 1'b0; force_data = 16'h0000; halt_addr = 16'h0001;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 16'h0000;
    next_pc = 16'h0000; imem_valid = 1'b0; imem_rdata = 16'h0000;
    exp_pc = RST_PC;

    // Stall with 3-cycle memory at pc 0x0010, released two cycles later.
    vecs[0] = mk(1'b0, 16'h0012, 1'b1, 16'h0010, 16'h0010, 16'h100E, 16'h0010, 1'b1);
    vecs[1] = mk(1'b0, 16'h0012, 1'b1, 16'h0010, 16'h0010, 16'h100E, 16'h0010, 1'b1);
    vecs[2] = mk(1'b1, 16'h0012, 1'b0, 16'h0000, 16'h0010, 16'h100E, 16'h0010, 1'b1);
    vecs[3] = mk(1'b1, 16'h0012, 1'b0, 16'h0000, 16'h0010, 16'h100E, 16'h0010, 1'b1);
    vecs[4] = mk(1'b0, 16'h0012, 1'b1, 16'h0012, 16'h0012, 16'h1010, 16'h0012, 1'b1);
    vecs[5] = mk(1'b0, 16'h0014, 1'b1, 16'h0012, 16'h0012, 16'h1010, 16'h0012, 1'b1);

    tick();
    tick();
    chk_reset("rst");
    rst_n = 1'b1;

    // IDLE -> FETCH, then the first request on the second edge.
    tick();
    chk("edge1_req", 16'(imem_req), 16'd0);
    tick();
    chk("edge2_req", 16'(imem_req), 16'd1);
    chk("edge2_addr", imem_addr, 16'h0000);
    chk("edge2_valid", 16'(if_id_valid), 16'd0);

    stream(8);

    lat = 3;
    for (int i = 0; i < 6; i++) begin
      stall   = vecs[i].stall;
      next_pc = vecs[i].nxt;
      tick();
      chk($sformatf("vec%0d_req", i), 16'(imem_req), 16'(vecs[i].req));
      if (vecs[i].req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      chk($sformatf("vec%0d_instr", i), if_id_instr, vecs[i].instr);
      chk($sformatf("vec%0d_pcp2", i), if_id_pc_plus2, vecs[i].pcp2);
      chk($sformatf("vec%0d_valid", i), 16'(if_id_valid), 16'(vecs[i].valid));
    end
    stall  = 1'b0;
    exp_pc = 16'h0012;

    lat = 1;
    stream(7);

    // Flush to 0x0100 while the read of 0x0020 is outstanding.
    lat = 3;
    flush = 1'b1; redirect_pc = 16'h0100;
    tick();
    flush = 1'b0;
    chk("drain0_valid", 16'(if_id_valid), 16'd0);
    chk("drain0_instr", if_id_instr, NOP);
    chk("drain0_pc", pc, 16'h0100);
    chk("drain0_addr", imem_addr, 16'h0020);
    tick();
    chk("drain1_valid", 16'(if_id_valid), 16'd0);
    chk("drain1_req", 16'(imem_req), 16'd1);
    tick();
    chk("drain2_instr", if_id_instr, NOP);
    chk("drain2_valid", 16'(if_id_valid), 16'd0);
    chk("drain2_req", 16'(imem_req), 16'd1);
    chk("drain2_addr", imem_addr, 16'h0100);

    // Flush coinciding with returned data, redirect to the HLT at 0x0040.
    lat = 1;
    halt_addr = 16'h0040;
    flush = 1'b1; redirect_pc = 16'h0040;
    tick();
    flush = 1'b0;
    chk("flvld_valid", 16'(if_id_valid), 16'd0);
    chk("flvld_addr", imem_addr, 16'h0040);
    chk("flvld_pc", pc, 16'h0040);
    next_pc = 16'h0042;
    tick();
    chk("hlt_halted", 16'(halted), 16'd1);
    chk("hlt_instr", if_id_instr, 16'hF000);
    chk("hlt_pcp2", if_id_pc_plus2, 16'h0042);
    chk("hlt_pc", pc, 16'h0040);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_req", 16'(imem_req), 16'd0);
      chk("halt_flag", 16'(halted), 16'd1);
      chk("halt_pc", pc, 16'h0040);
    end
    flush = 1'b1; redirect_pc = 16'h0060;
    tick();
    flush = 1'b0;
    chk("unhalt_halted", 16'(halted), 16'd0);
    chk("unhalt_req", 16'(imem_req), 16'd1);
    chk("unhalt_addr", imem_addr, 16'h0060);
    chk("unhalt_valid", 16'(if_id_valid), 16'd0);
    exp_pc = 16'h0060;
    stream(1);

    // Enter HOLD, then flush+stall with a stray imem_valid: skid must be dropped.
    stall = 1'b1;
    tick();
    chk("hold_req", 16'(imem_req), 16'd0);
    chk("hold_instr", if_id_instr, 16'h1060);
    chk("hold_pc", pc, 16'h0062);
    flush = 1'b1; redirect_pc = 16'h0080;
    force_vld = 1'b1; force_data = 16'hBEEF;
    tick();
    force_vld = 1'b0; flush = 1'b0; stall = 1'b0;
    chk("hflush_req", 16'(imem_req), 16'd1);
    chk("hflush_addr", imem_addr, 16'h0080);
    chk("hflush_pc", pc, 16'h0080);
    chk("hflush_valid", 16'(if_id_valid), 16'd0);
    chk("hflush_instr", if_id_instr, NOP);
    exp_pc = 16'h0080;
    stream(1);

    // PC wrap at 0xFFFE.
    flush = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    flush = 1'b0;
    chk("wrap_addr", imem_addr, 16'hFFFE);
    exp_pc = 16'hFFFE;
    stream(1);
    chk("wrap_pcp2", if_id_pc_plus2, 16'h0000);

    // Asynchronous reset in the middle of an outstanding read.
    lat = 3;
    tick();
    chk("mid_req", 16'(imem_req), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rerst1_req", 16'(imem_req), 16'd0);
    tick();
    chk("rerst2_req", 16'(imem_req), 16'd1);
    chk("rerst2_addr", imem_addr, RST_PC);

    chk("sb_empty", 16'(sb_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
